conv2d_lanes: RTL

Parametrised 2-D convolution engine with ReLU and saturation. It slides a SIZEKer×SIZEKer kernel over a SIZE×SIZE signed image held on its input port. It computes LANES output pixels per group in raster order with a configurable stride, and writes a registered, saturated output feature map. It sits between the image buffer and the pooling stage and signals completion with a one-cycle `done`.

---
 rtl/conv2d_lanes_if.sv | 20 ++
 rtl/conv2d_lanes.sv | 125 ++++++++++++
 2 files changed

// File: rtl/conv2d_lanes_if.sv
// conv2d_lanes_if: handshake and data bundle for conv2d_lanes.
// Signals: start (pass request), busy/done (status), inpMatrixI / kerMatrixI
// (image and kernel, held stable during a pass), convIxKernelOut (result map).
// master drives start and operands; slave is the convolution engine.
interface conv2d_lanes_if #(
  parameter int SIZE      = 7,
  parameter int SIZEKer   = 3,
  parameter int WIDTH_BIT = 8,
  parameter int STRIDE    = 1
);
  localparam int OUT = (SIZE - SIZEKer) / STRIDE + 1;
  logic start;
  logic busy;
  logic done;
  logic signed [WIDTH_BIT-1:0] inpMatrixI [SIZE][SIZE];
  logic signed [WIDTH_BIT-1:0] kerMatrixI [SIZEKer][SIZEKer];
  logic signed [WIDTH_BIT-1:0] convIxKernelOut [OUT][OUT];
  modport master (output start, inpMatrixI, kerMatrixI, input busy, done, convIxKernelOut);
  modport slave (input start, inpMatrixI, kerMatrixI, output busy, done, convIxKernelOut);
endinterface

// File: rtl/conv2d_lanes.sv
// conv2d_lanes: lane-parallel 2-D convolution with shift, saturation and optional ReLU.
// Ports: clock, reset (sync, active-high), bus (conv2d_lanes_if.slave):
//   start in, busy/done out, inpMatrixI/kerMatrixI in, convIxKernelOut out (registered).
// Macro CONV2D_LANES_RELU_EN: clamp negative results to zero before the upper clip;
// undefined gives plain signed saturation.
module conv2d_lanes #(
  parameter int SIZE      = 7,
  parameter int SIZEKer   = 3,
  parameter int WIDTH_BIT = 8,
  parameter int LANES     = 4,
  parameter int STRIDE    = 1,
  parameter int FRAC      = 0
) (
  input logic           clock,
  input logic           reset,
  conv2d_lanes_if.slave bus
);
  localparam int OUT  = (SIZE - SIZEKer) / STRIDE + 1;
  localparam int NPIX = OUT * OUT;
  localparam int ACCW = 2 * WIDTH_BIT + $clog2(SIZEKer * SIZEKer);
  localparam int PW   = $clog2(NPIX + LANES + 1);
  typedef logic signed [WIDTH_BIT-1:0] elem_t;
  typedef logic signed [ACCW-1:0] acc_t;
  typedef enum logic [2:0] {IDLE, LOAD, MAC, WRITE, DONE} state_t;
  localparam acc_t MAXV = acc_t'((2 ** (WIDTH_BIT - 1)) - 1);
`ifdef CONV2D_LANES_RELU_EN
  localparam acc_t ZERO = acc_t'(0);
`else
  localparam acc_t MINV = acc_t'(-(2 ** (WIDTH_BIT - 1)));
`endif
  state_t           state_q, state_d;
  logic [PW-1:0]    p_q, p_d;
  elem_t            win_q [LANES][SIZEKer][SIZEKer];
  elem_t            win_d [LANES][SIZEKer][SIZEKer];
  logic [LANES-1:0] vld_q, vld_d;
  acc_t             acc_q [LANES];
  acc_t             acc_d [LANES];
  elem_t            out_q [OUT][OUT];
  elem_t            out_d [OUT][OUT];
  acc_t             sum   [LANES];
  elem_t            res   [LANES];

  function automatic elem_t clip(acc_t a);
    acc_t r = a >>> FRAC;
`ifdef CONV2D_LANES_RELU_EN
    return r < ZERO ? '0 : r > MAXV ? elem_t'(MAXV) : elem_t'(r);
`else
    return r < MINV ? elem_t'(MINV) : r > MAXV ? elem_t'(MAXV) : elem_t'(r);
`endif
  endfunction

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      sum[l] = '0;
      for (int k = 0; k < SIZEKer; k++)
        for (int m = 0; m < SIZEKer; m++)
          sum[l] += acc_t'(win_q[l][k][m]) * acc_t'(bus.kerMatrixI[k][m]);
      res[l] = clip(acc_q[l]);
    end
  end

  // Window selection and write-back use a constant-index compare per output pixel,
  // so every array access resolves to a fixed location.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    win_d   = win_q;
    vld_d   = vld_q;
    acc_d   = acc_q;
    out_d   = out_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = LOAD;
        p_d     = '0;
      end
      LOAD: begin
        for (int l = 0; l < LANES; l++) begin
          vld_d[l] = (p_q + PW'(l)) < PW'(NPIX);
          for (int o = 0; o < NPIX; o++)
            if (p_q + PW'(l) == PW'(o))
              for (int k = 0; k < SIZEKer; k++)
                for (int m = 0; m < SIZEKer; m++)
                  win_d[l][k][m] = bus.inpMatrixI[(o / OUT) * STRIDE + k][(o % OUT) * STRIDE + m];
        end
        state_d = MAC;
      end
      MAC: begin
        for (int l = 0; l < LANES; l++)
          if (vld_q[l]) acc_d[l] = sum[l];
        state_d = WRITE;
      end
      WRITE: begin
        for (int l = 0; l < LANES; l++)
          for (int o = 0; o < NPIX; o++)
            if (vld_q[l] && p_q + PW'(l) == PW'(o)) out_d[o / OUT][o % OUT] = res[l];
        p_d     = p_q + PW'(LANES);
        state_d = p_d < PW'(NPIX) ? LOAD : DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      p_q     <= '0;
      win_q   <= '{default: '0};
      vld_q   <= '0;
      acc_q   <= '{default: '0};
      out_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      win_q   <= win_d;
      vld_q   <= vld_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
    end
  end

  assign bus.busy            = state_q != IDLE;
  assign bus.done            = state_q == DONE;
  assign bus.convIxKernelOut = out_q;
endmodule
